// File: rtl/rotate_shift_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : rotate_shift_pipe_pkg
// Brief  : Mode encodings shared by the rotate/shift pipeline and its bench.
// Rev    : 1.0  initial release
// ============================================================================
package rotate_shift_pipe_pkg;

  // Operation selected per word; travels down the pipe with the data.
  typedef enum logic [1:0] {
    RS_PASS = 2'b00,
    RS_REV  = 2'b01,
    RS_SHR  = 2'b10,
    RS_SHL  = 2'b11
  } rs_mode_e;

endpackage
`default_nettype wire

// File: rtl/rotate_shift_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : rotate_shift_pipe_if
// Brief  : Input/output handshake and data bundle of the rotate/shift pipe.
// Rev    : 1.0  initial release
// ============================================================================
interface rotate_shift_pipe_if #(
  parameter int SWR = 26,
  parameter int EWR = 5
);
  logic           flush_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [SWR-1:0] Data_i;
  logic [1:0]     mode_i;
  logic [EWR-1:0] shift_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [SWR-1:0] Data_o;
  logic           sticky_o;
  logic           busy_o;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output flush_i, in_valid_i, Data_i, mode_i, shift_i, out_ready_i,
    input  in_ready_o, out_valid_o, Data_o, sticky_o, busy_o
  );

  // Pipeline side.
  modport slave (
    input  flush_i, in_valid_i, Data_i, mode_i, shift_i, out_ready_i,
    output in_ready_o, out_valid_o, Data_o, sticky_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/rotate_shift_pipe_bit_reverse_stage.sv
`default_nettype none
// ============================================================================
// Module : bit_reverse_stage
// Brief  : Combinational optional bit reversal, y[j] = en ? x[SWR-1-j] : x[j].
//          For odd SWR the centre bit maps onto itself.
// Rev    : 1.0  initial release
// ============================================================================
module bit_reverse_stage #(
  parameter int SWR = 26
) (
  input  wire           i_en,
  input  wire [SWR-1:0] i_x,
  output wire [SWR-1:0] o_y
);

  // One 2:1 mux per output bit.
  for (genvar j = 0; j < SWR; j++) begin : g_bit
    assign o_y[j] = i_en ? i_x[SWR-1-j] : i_x[j];
  end

endmodule
`default_nettype wire

// File: rtl/rotate_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module : rotate_shift_pipe
// Brief  : Three-stage pass / reverse / shift-right / shift-left unit with a
//          sticky bit. Left shift = reverse -> right shift -> reverse.
//          Stages hand off with a combinational ready chain, no skid buffer.
// Rev    : 1.0  initial release
// ============================================================================
module rotate_shift_pipe
  import rotate_shift_pipe_pkg::*;
#(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  wire                clk,
  input  wire                rst,   // asynchronous, active-low
  rotate_shift_pipe_if.slave bus
);

  // Stage state
  logic           r_s1_vld, r_s2_vld, r_s3_vld;
  logic [SWR-1:0] r_s1_data, r_s2_data, r_s3_data;
  rs_mode_e       r_s1_mode, r_s2_mode;
  logic [EWR-1:0] r_s1_shift;
  logic           r_s2_sticky, r_s3_sticky;

  // Handshake chain: a stage moves when empty or when its successor moves.
  logic w_s1_adv, w_s2_adv, w_s3_adv, w_accept;
  assign w_s3_adv = !r_s3_vld || bus.out_ready_i;
  assign w_s2_adv = !r_s2_vld || w_s3_adv;
  assign w_s1_adv = !r_s1_vld || w_s2_adv;
  assign bus.in_ready_o = !bus.flush_i && w_s1_adv;
  assign w_accept = bus.in_valid_i && bus.in_ready_o;

  // S1 input: pre-reverse the operand for left shifts.
  rs_mode_e       w_mode_in;
  logic [SWR-1:0] w_s1_din;
  assign w_mode_in = rs_mode_e'(bus.mode_i);

  bit_reverse_stage #(.SWR(SWR)) u_rev_in (
    .i_en (w_mode_in == RS_SHL),
    .i_x  (bus.Data_i),
    .o_y  (w_s1_din)
  );

  // S2 shifter: logical right shift, sticky collects every dropped bit.
  logic [SWR-1:0] w_s2_din;
  logic           w_s2_sticky;
  logic [SWR-1:0] w_drop_mask;
  assign w_drop_mask = ~({SWR{1'b1}} << r_s1_shift);

  // Shift amounts at or beyond the width flush the whole operand into sticky.
  always_comb begin
    w_s2_din    = r_s1_data;
    w_s2_sticky = 1'b0;
    case (r_s1_mode)
      RS_SHR, RS_SHL: begin
        if (int'(r_s1_shift) >= SWR) begin
          w_s2_din    = '0;
          w_s2_sticky = |r_s1_data;
        end else begin
          w_s2_din    = r_s1_data >> r_s1_shift;
          w_s2_sticky = |(r_s1_data & w_drop_mask);
        end
      end
      RS_PASS, RS_REV: begin
        w_s2_din    = r_s1_data;
        w_s2_sticky = 1'b0;
      end
      default: ;
    endcase
  end

  // S3 input: reverse back for left shifts, reverse once for plain reverse.
  logic [SWR-1:0] w_s3_din;

  bit_reverse_stage #(.SWR(SWR)) u_rev_out (
    .i_en ((r_s2_mode == RS_REV) || (r_s2_mode == RS_SHL)),
    .i_x  (r_s2_data),
    .o_y  (w_s3_din)
  );

  // Pipeline registers; flush drops every word, data regs only load real words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s3_vld    <= 1'b0;
      r_s1_data   <= '0;
      r_s2_data   <= '0;
      r_s3_data   <= '0;
      r_s1_mode   <= RS_PASS;
      r_s2_mode   <= RS_PASS;
      r_s1_shift  <= '0;
      r_s2_sticky <= 1'b0;
      r_s3_sticky <= 1'b0;
    end else if (bus.flush_i) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= bus.in_valid_i;
        if (w_accept) begin
          r_s1_data  <= w_s1_din;
          r_s1_mode  <= w_mode_in;
          r_s1_shift <= bus.shift_i;
        end
      end
      if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_data   <= w_s2_din;
          r_s2_mode   <= r_s1_mode;
          r_s2_sticky <= w_s2_sticky;
        end
      end
      if (w_s3_adv) begin
        r_s3_vld <= r_s2_vld;
        if (r_s2_vld) begin
          r_s3_data   <= w_s3_din;
          r_s3_sticky <= r_s2_sticky;
        end
      end
    end
  end

  assign bus.out_valid_o = r_s3_vld;
  assign bus.Data_o      = r_s3_data;
  assign bus.sticky_o    = r_s3_sticky;
  assign bus.busy_o      = r_s1_vld || r_s2_vld || r_s3_vld;

endmodule
`default_nettype wire

// File: tb/tb_rotate_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_rotate_shift_pipe
// Brief  : Directed vector table plus back-pressure, flush, reset and a
//          randomised stream scored against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rotate_shift_pipe;

  localparam int SWR = 26;
  localparam int EWR = 5;
  localparam int NVEC = 15;
  localparam int NRND = 150;

  typedef struct {
    logic [SWR-1:0] d;
    logic [1:0]     m;
    logic [EWR-1:0] sh;
    logic [SWR-1:0] ed;
    logic           es;
  } vec_t;

  typedef struct {
    logic [SWR-1:0] d;
    logic           s;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rotate_shift_pipe_if #(.SWR(SWR), .EWR(EWR)) bus ();

  rotate_shift_pipe #(.SWR(SWR), .EWR(EWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: widen the operand so discarded bits land in a separate field.
  function automatic res_t model(input logic [SWR-1:0] d, input logic [1:0] m,
                                 input logic [EWR-1:0] sh);
    res_t r;
    logic [SWR+31:0] t;
    r.d = d;
    r.s = 1'b0;
    t   = '0;
    case (m)
      2'b01: for (int j = 0; j < SWR; j++) r.d[j] = d[SWR-1-j];
      2'b10: begin
        t   = {d, 32'b0} >> sh;
        r.d = t[SWR+31:32];
        r.s = |t[31:0];
      end
      2'b11: begin
        t   = {32'b0, d} << sh;
        r.d = t[SWR-1:0];
        r.s = |t[SWR+31:SWR];
      end
      default: ;
    endcase
    return r;
  endfunction

  vec_t           vecs [NVEC];
  logic [SWR-1:0] bp_w [5];
  res_t           exp_q [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, k, acc, sent, got, seen;
    logic [SWR-1:0] cap_d;
    logic cap_s;
    logic [SWR-1:0] cur_d;
    logic [1:0] cur_m;
    logic [EWR-1:0] cur_s;
    res_t e;

    vecs[0]  = '{26'h0000001, 2'b01, 5'd7,  26'h2000000, 1'b0};
    vecs[1]  = '{26'h00000FF, 2'b10, 5'd4,  26'h000000F, 1'b1};
    vecs[2]  = '{26'h00000F0, 2'b10, 5'd4,  26'h000000F, 1'b0};
    vecs[3]  = '{26'h0000001, 2'b11, 5'd3,  26'h0000008, 1'b0};
    vecs[4]  = '{26'h3000000, 2'b11, 5'd1,  26'h2000000, 1'b1};
    vecs[5]  = '{26'h0000400, 2'b10, 5'd26, 26'h0000000, 1'b1};
    vecs[6]  = '{26'h0000400, 2'b10, 5'd31, 26'h0000000, 1'b1};
    vecs[7]  = '{26'h0000000, 2'b10, 5'd26, 26'h0000000, 1'b0};
    vecs[8]  = '{26'h3ABCDEF, 2'b00, 5'd5,  26'h3ABCDEF, 1'b0};
    vecs[9]  = '{26'h3000000, 2'b01, 5'd0,  26'h0000003, 1'b0};
    vecs[10] = '{26'h1234567, 2'b10, 5'd0,  26'h1234567, 1'b0};
    vecs[11] = '{26'h0000003, 2'b11, 5'd25, 26'h2000000, 1'b1};
    vecs[12] = '{26'h2000001, 2'b10, 5'd25, 26'h0000001, 1'b1};
    vecs[13] = '{26'h0000001, 2'b11, 5'd26, 26'h0000000, 1'b1};
    vecs[14] = '{26'h0000002, 2'b11, 5'd31, 26'h0000000, 1'b1};
    for (int i = 0; i < 5; i++) bp_w[i] = 26'h0ABC000 + 26'(i);

    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    bus.Data_i = '0; bus.mode_i = 2'b00; bus.shift_i = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_data",      32'(bus.Data_o),      32'd0);
    check("rst_sticky",    32'(bus.sticky_o),    32'd0);
    check("rst_busy",      32'(bus.busy_o),      32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;

    // Directed table, one word at a time, latency measured
    for (int i = 0; i < NVEC; i++) begin
      bus.Data_i = vecs[i].d; bus.mode_i = vecs[i].m; bus.shift_i = vecs[i].sh;
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready_o), 32'd1);
      @(posedge clk); #1;
      bus.in_valid_i = 1'b0;
      bus.Data_i = ~vecs[i].d; bus.mode_i = ~vecs[i].m; bus.shift_i = ~vecs[i].sh;
      lat = 0; cap_d = '0; cap_s = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (bus.out_valid_o && lat == 0) begin
          lat = c; cap_d = bus.Data_o; cap_s = bus.sticky_o;
        end
        @(posedge clk); #1;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat),   32'd3);
      check($sformatf("vec%0d_data", i),    32'(cap_d), 32'(vecs[i].ed));
      check($sformatf("vec%0d_sticky", i),  32'(cap_s), 32'(vecs[i].es));
    end

    // Back-pressure: 5 words offered, only 3 fit while the output stalls
    bus.out_ready_i = 1'b0; bus.mode_i = 2'b00; bus.shift_i = '0;
    k = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid_i = 1'b1; bus.Data_i = bp_w[k];
      @(negedge clk);
      if (bus.in_ready_o) begin acc++; k++; end
      if (bus.out_valid_o) check("bp_hold_data", 32'(bus.Data_o), 32'(bp_w[0]));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_accepted",  32'(acc),                32'd3);
    check("bp_in_ready",  32'(bus.in_ready_o),     32'd0);
    check("bp_out_valid", 32'(bus.out_valid_o),    32'd1);
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid_i = (k < 5); bus.Data_i = bp_w[k < 5 ? k : 4];
      @(negedge clk);
      check($sformatf("bp_out%0d_valid", i), 32'(bus.out_valid_o), 32'd1);
      check($sformatf("bp_out%0d_data", i),  32'(bus.Data_o),      32'(bp_w[i]));
      if (bus.in_valid_i && bus.in_ready_o) k++;
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
    check("bp_all_sent", 32'(k), 32'd5);
    @(negedge clk);
    check("bp_drained_busy", 32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;

    // Flush with two words in flight; the word offered during flush is dropped
    bus.in_valid_i = 1'b1; bus.Data_i = 26'h0000011; bus.mode_i = 2'b00;
    @(posedge clk); #1;
    bus.Data_i = 26'h0000022;
    @(posedge clk); #1;
    bus.Data_i = 26'h0000033; bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready_o), 32'd0);
    check("flush_busy_pre", 32'(bus.busy_o),     32'd1);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("flush_busy",      32'(bus.busy_o),      32'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    check("flush_no_output", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Randomised stream scored against the model
    sent = 0; got = 0;
    cur_d = 26'($urandom); cur_m = 2'($urandom); cur_s = 5'($urandom);
    for (int c = 0; c < 3000 && (sent < NRND || got < NRND); c++) begin
      bus.in_valid_i  = (sent < NRND) && ($urandom_range(0, 9) < 7);
      bus.Data_i = cur_d; bus.mode_i = cur_m; bus.shift_i = cur_s;
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          got++;
          check("rnd_data",   32'(bus.Data_o),   32'(e.d));
          check("rnd_sticky", 32'(bus.sticky_o), 32'(e.s));
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        exp_q.push_back(model(cur_d, cur_m, cur_s));
        sent++;
        cur_d = 26'($urandom); cur_m = 2'($urandom); cur_s = 5'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    check("rnd_words_out", 32'(got), 32'(NRND));

    // Async reset with a stalled word at the output
    bus.out_ready_i = 1'b0;
    bus.in_valid_i = 1'b1; bus.Data_i = 26'h0000003; bus.mode_i = 2'b10; bus.shift_i = 5'd1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_pre_valid",  32'(bus.out_valid_o), 32'd1);
    check("arst_pre_data",   32'(bus.Data_o),      32'd1);
    check("arst_pre_sticky", 32'(bus.sticky_o),    32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid_o), 32'd0);
    check("arst_data",      32'(bus.Data_o),      32'd0);
    check("arst_sticky",    32'(bus.sticky_o),    32'd0);
    check("arst_busy",      32'(bus.busy_o),      32'd0);
    @(posedge clk); #1;
    rst = 1'b1; bus.out_ready_i = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(bus.in_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
